// File: rtl/i2c_fnv_host_ctrl.sv
// i2c_fnv_host_ctrl
//   Single-master I2C controller that talks to the FNV-1a hasher target.
//   The user side issues one byte per command and gets one response per
//   command. The bus side is open-drain: *_oe = 1 pulls the line low.
//   The controller honours target clock stretching.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (see below)
//   cmd_start         issue START / repeated START and the address byte first
//   cmd_stop          issue STOP after the data byte
//   cmd_read          1 = read one byte, 0 = write cmd_data
//   cmd_nack          read only: answer the byte with NACK instead of ACK
//   cmd_data          byte to write
//   rsp_valid         one-cycle completion pulse
//   rsp_data          byte read (0 for writes and for address NACK)
//   rsp_nack          target NACKed the address or the written byte
//   busy              bus owned (START issued, STOP not yet issued)
//   scl_in, sda_in    synchronized bus levels
//   scl_oe, sda_oe    1 = pull line low, 0 = release
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid & cmd_ready are both 1. All cmd_* fields are latched on that
// edge. cmd_ready is 1 only while idle or holding the bus between bytes.
// Exactly one rsp_valid pulse follows each accepted command. cmd_ready
// rises in the same cycle as that pulse.
module i2c_fnv_host_ctrl #(
   parameter int         CLK_DIV     = 30,
   parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_read,
   input  logic       cmd_nack,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_nack,
   output logic       busy,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_RSTART, S_ADDR, S_ADDR_ACK,
      S_DATA, S_DATA_ACK, S_STOP, S_HOLD, S_DONE
   } state_t;

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   state_t           state, state_d;
   logic [DIV_W-1:0] div;
   logic [1:0]       qtr;      // quarter of the current bit cell / sequence
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [7:0]       data_q;
   logic             stop_q, read_q, nack_cmd_q;
   logic             nack_q;   // NACK seen on address or write data
   logic             active, stall, tick, q_end, accept;

   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      active = 1'b0;
      stall  = 1'b0;
      case (state)
         S_START:                                active = 1'b1;
         S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK: begin
            active = 1'b1;
            // released SCL may be held low by the target: the quarter
            // does not start counting until the line is really high
            stall  = (qtr == 2'd2) && !scl_in;
         end
         S_RSTART, S_STOP: begin
            active = 1'b1;
            stall  = (qtr == 2'd1) && !scl_in;
         end
         default: ;
      endcase
   end

   assign tick  = active && !stall && (div == DIV_LAST);
   assign q_end = tick && (qtr == 2'd3);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // next state and bus/handshake outputs
   always_comb begin
      state_d   = state;
      scl_oe    = 1'b0;
      sda_oe    = 1'b0;
      cmd_ready = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = S_START;
         end
         S_HOLD: begin
            cmd_ready = 1'b1;
            scl_oe    = 1'b1;
            if (cmd_valid) state_d = cmd_start ? S_RSTART : S_DATA;
         end
         S_START: begin
            // q0: SDA low with SCL high, q1: SCL low
            sda_oe = 1'b1;
            scl_oe = (qtr == 2'd1);
            if (tick && qtr == 2'd1) state_d = S_ADDR;
         end
         S_RSTART: begin
            // q0: SDA up, q1: SCL up, q2: SDA down, q3: SCL down
            scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
            sda_oe = qtr[1];
            if (q_end) state_d = S_ADDR;
         end
         S_ADDR: begin
            scl_oe = !qtr[1];
            sda_oe = !shreg[7];
            if (q_end && bit_cnt == 3'd7) state_d = S_ADDR_ACK;
         end
         S_ADDR_ACK: begin
            scl_oe = !qtr[1];
            if (q_end) state_d = sda_in ? S_STOP : S_DATA;
         end
         S_DATA: begin
            scl_oe = !qtr[1];
            sda_oe = !read_q && !shreg[7];
            if (q_end && bit_cnt == 3'd7) state_d = S_DATA_ACK;
         end
         S_DATA_ACK: begin
            scl_oe = !qtr[1];
            sda_oe = read_q && !nack_cmd_q;
            if (q_end) state_d = stop_q ? S_STOP : S_DONE;
         end
         S_STOP: begin
            // q0: SDA down, q1: SCL up, q2: SDA up, q3: bus free
            scl_oe = (qtr == 2'd0);
            sda_oe = !qtr[1];
            if (q_end) state_d = S_DONE;
         end
         S_DONE: begin
            // busy is already clear here when a STOP was just issued
            scl_oe  = busy;
            state_d = busy ? S_HOLD : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // divider, bit timing and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div        <= '0;
         qtr        <= 2'd0;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         data_q     <= 8'h00;
         stop_q     <= 1'b0;
         read_q     <= 1'b0;
         nack_cmd_q <= 1'b0;
         nack_q     <= 1'b0;
         busy       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 8'h00;
         rsp_nack   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;

         if (!active || stall || tick) div <= '0;
         else                          div <= div + 1'b1;

         if (state_d != state) begin
            qtr     <= 2'd0;
            bit_cnt <= 3'd0;
         end else if (tick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd3) bit_cnt <= bit_cnt + 3'd1;
         end

         if (accept) begin
            data_q     <= cmd_data;
            stop_q     <= cmd_stop;
            read_q     <= cmd_read;
            nack_cmd_q <= cmd_nack;
            nack_q     <= 1'b0;
            // only a HOLD continuation without start skips the address
            shreg      <= (state == S_HOLD && !cmd_start) ? cmd_data
                                                          : {TARGET_ADDR, cmd_read};
         end

         if (state == S_START) busy <= 1'b1;

         if (q_end) begin
            case (state)
               S_ADDR, S_DATA: shreg <= {shreg[6:0], sda_in};
               S_ADDR_ACK: begin
                  nack_q <= sda_in;
                  shreg  <= data_q;
               end
               S_DATA_ACK: if (!read_q) nack_q <= sda_in;
               S_STOP:     busy <= 1'b0;
               default: ;
            endcase
         end

         if (state == S_DONE) begin
            rsp_valid <= 1'b1;
            rsp_nack  <= nack_q;
            rsp_data  <= (read_q && !nack_q) ? shreg : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_i2c_fnv_host_ctrl.sv
// Directed bench for i2c_fnv_host_ctrl with a small behavioural I2C target
// and bus monitor (frames, START/STOP counts, SCL rise-to-rise period).
module tb_i2c_fnv_host_ctrl;
   localparam int CLK_DIV = 30;
   localparam int TMO     = 20000;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // DUT
   logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
   logic       cmd_read = 1'b0, cmd_nack = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
   logic [7:0] rsp_data;
   logic       stretch = 1'b0;
   logic       tgt_sda = 1'b0;
   logic       tgt_present = 1'b1;
   logic       scl_in, sda_in;

   assign scl_in = ~(scl_oe | stretch);
   assign sda_in = ~(sda_oe | tgt_sda);

   i2c_fnv_host_ctrl #(.CLK_DIV(CLK_DIV), .TARGET_ADDR(7'h2A)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
      .cmd_nack(cmd_nack), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
      .busy(busy),
      .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
   );

   // bus monitor + target model
   logic [7:0] rd_bytes [4];
   logic [8:0] mon_q [$];
   logic [8:0] rsp_q [$];
   logic [8:0] exp_q [$];
   logic [8:0] frame = 9'h0;
   int   mon_bit = 0, rd_idx = 0;
   logic is_addr = 1'b0, rd_mode = 1'b0;
   logic scl_p = 1'b1, sda_p = 1'b1, ready_p = 1'b1;
   int   n_start = 0, n_stop = 0, n_rsp = 0, n_ready_rise = 0;
   int   last_rise = 0, period_last = 0, period_max = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_bit = 0; is_addr = 1'b0; rd_mode = 1'b0; tgt_sda = 1'b0;
         scl_p = 1'b1; sda_p = 1'b1; ready_p = 1'b1;
      end else begin
         if (scl_in && scl_p && sda_p && !sda_in) begin
            n_start++; mon_bit = 0; is_addr = 1'b1; rd_mode = 1'b0; rd_idx = 0;
         end else if (scl_in && scl_p && !sda_p && sda_in) begin
            n_stop++; mon_bit = 0; is_addr = 1'b0; rd_mode = 1'b0; tgt_sda = 1'b0;
         end
         if (scl_in && !scl_p) begin
            if (mon_bit >= 1 && mon_bit <= 8) begin
               period_last = cyc - last_rise;
               if (period_last > period_max) period_max = period_last;
            end
            last_rise = cyc;
            if (mon_bit < 9) begin
               frame = {frame[7:0], sda_in};
               mon_bit++;
               if (mon_bit == 9) mon_q.push_back(frame);
            end
         end
         if (!scl_in && scl_p) begin
            if (mon_bit == 8) begin
               tgt_sda = rd_mode ? 1'b0 : tgt_present;
            end else if (mon_bit == 9) begin
               if (is_addr) rd_mode = tgt_present && frame[1] && !frame[0];
               else if (rd_mode) begin
                  rd_idx++;
                  if (frame[0]) rd_mode = 1'b0;
               end
               is_addr = 1'b0;
               mon_bit = 0;
               tgt_sda = 1'b0;
               if (rd_mode) tgt_sda = ~rd_bytes[rd_idx][7];
            end else if (mon_bit >= 1 && mon_bit <= 7 && rd_mode) begin
               tgt_sda = ~rd_bytes[rd_idx][7-mon_bit];
            end
         end
         if (rsp_valid) begin
            n_rsp++;
            rsp_q.push_back({rsp_nack, rsp_data});
         end
         if (cmd_ready && !ready_p) n_ready_rise++;
         ready_p = cmd_ready;
         scl_p = scl_in;
         sda_p = sda_in;
      end
   end

   // scoreboard
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_frames(input string tag);
      logic [8:0] e;
      check({tag, "_frame_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (mon_q.size() > 0) check({tag, "_frame"}, {23'h0, mon_q.pop_front()}, {23'h0, e});
         else                  check({tag, "_frame"}, 32'hDEAD, {23'h0, e});
      end
      mon_q.delete();
   endtask

   // driver tasks
   task automatic send_cmd(input logic s, input logic st, input logic rd,
                           input logic nk, input logic [7:0] d);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < TMO) begin @(negedge clk); t++; end
      check("ready_timeout", 32'(t >= TMO), 32'h0);
      cmd_valid = 1'b1; cmd_start = s; cmd_stop = st; cmd_read = rd;
      cmd_nack = nk; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic nk, output logic [7:0] d);
      int t = 0;
      logic [8:0] r;
      while (rsp_q.size() == 0 && t < TMO) begin @(negedge clk); t++; end
      check("rsp_timeout", 32'(t >= TMO), 32'h0);
      r = (rsp_q.size() > 0) ? rsp_q.pop_front() : 9'h1EE;
      nk = r[8];
      d  = r[7:0];
   endtask

   task automatic do_cmd(input logic s, input logic st, input logic rd,
                         input logic nk, input logic [7:0] d,
                         output logic onk, output logic [7:0] od);
      send_cmd(s, st, rd, nk, d);
      wait_rsp(onk, od);
   endtask

   // directed sequence
   initial begin
      logic       nk;
      logic [7:0] d;
      logic [7:0] b2b [3];
      int s0, p0, r0, q0, t;

      rd_bytes[0] = 8'hE4; rd_bytes[1] = 8'h0C;
      rd_bytes[2] = 8'h29; rd_bytes[3] = 8'h2C;
      b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_scl_oe", 32'(scl_oe), 32'h0);
      check("rst_sda_oe", 32'(sda_oe), 32'h0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      check("rst_rsp_nack", 32'(rsp_nack), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: write 0x61 with start+stop, target ACKs
      s0 = n_start; p0 = n_stop; r0 = n_rsp;
      do_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h61, nk, d);
      repeat (4) @(negedge clk);
      check("w1_nack", 32'(nk), 32'h0);
      check("w1_data", 32'(d), 32'h0);
      check("w1_busy", 32'(busy), 32'h0);
      check("w1_starts", 32'(n_start - s0), 32'h1);
      check("w1_stops", 32'(n_stop - p0), 32'h1);
      check("w1_rsp_count", 32'(n_rsp - r0), 32'h1);
      check("w1_scl_period", 32'(period_last), 32'd120);
      exp_q.push_back({8'h54, 1'b0});
      exp_q.push_back({8'h61, 1'b0});
      expect_frames("w1");

      // 2: target absent, address NACK forces STOP
      tgt_present = 1'b0;
      s0 = n_start; p0 = n_stop;
      do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h61, nk, d);
      repeat (4) @(negedge clk);
      check("an_nack", 32'(nk), 32'h1);
      check("an_data", 32'(d), 32'h0);
      check("an_stops", 32'(n_stop - p0), 32'h1);
      check("an_busy", 32'(busy), 32'h0);
      check("an_ready", 32'(cmd_ready), 32'h1);
      exp_q.push_back({8'h54, 1'b1});
      expect_frames("an");
      tgt_present = 1'b1;

      // 3: write "a", repeated START, read 4 hash bytes
      s0 = n_start; p0 = n_stop;
      do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h61, nk, d);
      check("rd_wr_nack", 32'(nk), 32'h0);
      check("rd_hold_busy", 32'(busy), 32'h1);
      check("rd_hold_scl", 32'(scl_oe), 32'h1);
      do_cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, nk, d);
      check("rd_b0", {23'h0, nk, d}, {23'h0, 1'b0, 8'hE4});
      do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, nk, d);
      check("rd_b1", {23'h0, nk, d}, {23'h0, 1'b0, 8'h0C});
      do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, nk, d);
      check("rd_b2", {23'h0, nk, d}, {23'h0, 1'b0, 8'h29});
      do_cmd(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, nk, d);
      check("rd_b3", {23'h0, nk, d}, {23'h0, 1'b0, 8'h2C});
      repeat (4) @(negedge clk);
      check("rd_starts", 32'(n_start - s0), 32'h2);
      check("rd_stops", 32'(n_stop - p0), 32'h1);
      check("rd_busy", 32'(busy), 32'h0);
      exp_q.push_back({8'h54, 1'b0});
      exp_q.push_back({8'h61, 1'b0});
      exp_q.push_back({8'h55, 1'b0});
      exp_q.push_back({8'hE4, 1'b0});
      exp_q.push_back({8'h0C, 1'b0});
      exp_q.push_back({8'h29, 1'b0});
      exp_q.push_back({8'h2C, 1'b1});
      expect_frames("rd");

      // 4: target stretches SCL for 200 clk during data bit 3
      s0 = n_start; p0 = n_stop;
      send_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
      t = 0;
      while (!(!is_addr && mon_bit == 3 && !scl_in) && t < TMO) begin @(negedge clk); t++; end
      check("cs_wait_timeout", 32'(t >= TMO), 32'h0);
      stretch = 1'b1;
      repeat (200) @(negedge clk);
      stretch = 1'b0;
      wait_rsp(nk, d);
      repeat (4) @(negedge clk);
      check("cs_nack", 32'(nk), 32'h0);
      check("cs_stretched", 32'(period_max > 200), 32'h1);
      check("cs_starts", 32'(n_start - s0), 32'h1);
      check("cs_stops", 32'(n_stop - p0), 32'h1);
      exp_q.push_back({8'h54, 1'b0});
      exp_q.push_back({8'hA5, 1'b0});
      expect_frames("cs");

      // 5: back-to-back writes with cmd_valid held high
      s0 = n_start; p0 = n_stop; r0 = n_rsp; q0 = n_ready_rise;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         cmd_valid = 1'b1; cmd_start = (k == 0); cmd_stop = (k == 2);
         cmd_read = 1'b0; cmd_nack = 1'b0; cmd_data = b2b[k];
         t = 0;
         while (!cmd_ready && t < TMO) begin @(negedge clk); t++; end
         check("bb_ready_timeout", 32'(t >= TMO), 32'h0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_rsp(nk, d);
         check("bb_rsp", {23'h0, nk, d}, 32'h0);
      end
      repeat (4) @(negedge clk);
      check("bb_rsp_count", 32'(n_rsp - r0), 32'h3);
      check("bb_starts", 32'(n_start - s0), 32'h1);
      check("bb_stops", 32'(n_stop - p0), 32'h1);
      check("bb_ready_rises", 32'(n_ready_rise - q0), 32'h3);
      exp_q.push_back({8'h54, 1'b0});
      exp_q.push_back({8'h11, 1'b0});
      exp_q.push_back({8'h22, 1'b0});
      exp_q.push_back({8'h33, 1'b0});
      expect_frames("bb");

      // 6: reset in the middle of data bit 4
      send_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h61);
      t = 0;
      while (!(!is_addr && mon_bit == 4 && !scl_in) && t < TMO) begin @(negedge clk); t++; end
      check("mr_wait_timeout", 32'(t >= TMO), 32'h0);
      check("mr_pre_busy", 32'(busy), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("mr_scl_oe", 32'(scl_oe), 32'h0);
      check("mr_sda_oe", 32'(sda_oe), 32'h0);
      check("mr_cmd_ready", 32'(cmd_ready), 32'h1);
      check("mr_busy", 32'(busy), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mon_q.delete();
      rsp_q.delete();
      repeat (2) @(negedge clk);
      s0 = n_start; p0 = n_stop;
      do_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, nk, d);
      repeat (4) @(negedge clk);
      check("mr_next_nack", 32'(nk), 32'h0);
      check("mr_next_starts", 32'(n_start - s0), 32'h1);
      check("mr_next_stops", 32'(n_stop - p0), 32'h1);
      exp_q.push_back({8'h54, 1'b0});
      exp_q.push_back({8'h3C, 1'b0});
      expect_frames("mr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_fnv_host_ctrl.md
Name: i2c_fnv_host_ctrl

Overview:
- I2C controller (initiator) that drives the FNV-1a hasher's I2C target interface from FPGA-side logic: streams message bytes in and reads the 32-bit hash back.
- Byte-level command/response handshake on the user side; open-drain SCL/SDA on the bus side.
- Single controller only: no multi-master arbitration. It does honour target clock stretching.

Parameters:
- CLK_DIV, 30, clk cycles per SCL quarter-period. SCL period = 4*CLK_DIV, so 100 kHz at 12 MHz.
- TARGET_ADDR, 7'h2A, 7-bit address of the hasher target.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_start  in  1  issue START (or repeated START) plus address byte before the data byte
- cmd_stop  in  1  issue STOP after the data byte
- cmd_read  in  1  1 = read a byte, 0 = write cmd_data
- cmd_nack  in  1  read only: controller sends NACK instead of ACK after the byte
- cmd_data  in  8  write byte
- rsp_valid  out  1  one-cycle pulse when a command completes
- rsp_data  out  8  byte read (0 for writes)
- rsp_nack  out  1  target NACKed the address or write data
- busy  out  1  bus owned (START issued, STOP not yet issued)
- scl_in, sda_in  in  1  synchronized bus levels
- scl_oe, sda_oe  out  1  1 = pull line low, 0 = release

Behaviour:
- Reset (async) forces: scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_nack=0, busy=0, FSM=IDLE, divider=0.
- Reset mid-transfer releases both lines immediately. No STOP is generated.
- Tick: divider counts 0..CLK_DIV-1 and pulses at CLK_DIV-1. All bus transitions occur on ticks.
- States: IDLE, START, RSTART, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, HOLD, DONE.
- Handshake:
  - cmd_ready=1 only in IDLE and HOLD.
  - On cmd_valid&cmd_ready all cmd_* fields are latched and cmd_ready drops the next cycle.
  - If the command arrives in IDLE, START is always issued, regardless of cmd_start.
- Bit cell, 4 quarters:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2: SCL released; the quarter does not begin counting until scl_in=1 (clock stretching, unbounded wait).
  - Q3: SCL high; SDA sampled on the final clk of Q3.
  - Then SCL low and the next bit's Q0.
- START from IDLE: SDA low for 1 quarter with SCL high, then SCL low 1 quarter. Sets busy=1.
- RSTART (cmd_start while in HOLD): release SDA (Q0), release SCL and wait for scl_in=1 (Q1), pull SDA low (Q2), pull SCL low (Q3).
- ADDR: shift {TARGET_ADDR, cmd_read} MSB first. ADDR_ACK samples SDA with sda_oe=0.
  - Address NACK (1) skips DATA and always goes to STOP, regardless of cmd_stop.
  - Completion then reports rsp_nack=1, rsp_data=0.
- DATA write: shift cmd_data MSB first. DATA_ACK samples ACK; rsp_nack = sampled bit.
- DATA read: sda_oe=0 for 8 bits, sampled MSB first into the shift register. DATA_ACK drives sda_oe = ~cmd_nack.
- After DATA_ACK:
  - cmd_stop=1 goes to STOP.
  - Otherwise go to HOLD with SCL held low (sda_oe=0, scl_oe=1), busy=1.
- STOP: SDA low (Q0), release SCL and wait for scl_in=1 (Q1), release SDA (Q2), 1-quarter bus-free (Q3). Then busy=0.
- DONE: rsp_valid=1 for exactly one clk, with rsp_data/rsp_nack valid in the same cycle and held until the next completion.
- Next state: IDLE if STOP was issued, else HOLD. cmd_ready rises the same cycle as rsp_valid.
- A write NACK with cmd_stop=0 still goes to HOLD. The user decides whether to STOP.
- A command with cmd_start=0 in HOLD continues the transfer with no address byte.

Test Plan:
- Write, start+stop, data 0x61, target ACKs → bus carries START, 0x54, ACK, 0x61, ACK, STOP; one rsp_valid with rsp_nack=0, busy returns to 0; SCL period measures 120 clk.
- Address NACK: target absent, write 0x61 with cmd_stop=0 → STOP still issued after the address; rsp_nack=1, rsp_data=0; no data bits clocked.
- After writing "a": repeated START then read 4 bytes, nack on the 4th plus stop → address byte 0x55; rsp_data sequence E4, 0C, 29, 2C (FNV-1a "a" = 0xE40C292C); ACK, ACK, ACK, NACK, then STOP.
- Clock stretch: target holds SCL low 200 clk during bit 3 of a write → Q2/Q3 delayed until release; no SDA change while SCL is high; data is correct.
- Back-to-back: cmd_valid held high with 3 write commands (first start, last stop) → exactly one START and one STOP; cmd_ready pulses between bytes; 3 rsp_valid pulses.
- rst_n low mid-DATA bit 4 → scl_oe=sda_oe=0 the same cycle, cmd_ready=1, busy=0; the next command begins with START.
